// File: rtl/regfile.sv
// 32 x 32-bit MIPS register file: two combinational read ports and one clocked write port.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    localparam int NUM_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              bypass1;
    logic              bypass2;

    // A write during reset is dropped; r0 is never written so it stays zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign bypass1 = we && (waddr == raddr1);
    assign bypass2 = we && (waddr == raddr2);
`else
    assign bypass1 = 1'b0;
    assign bypass2 = 1'b0;
`endif

    always_comb begin
        rdata1 = '0;
        if (rst && re1 && (raddr1 != '0)) begin
            rdata1 = bypass1 ? wdata : regs[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (rst && re2 && (raddr2 != '0)) begin
            rdata2 = bypass2 ? wdata : regs[raddr2];
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: a per-cycle reference model plus directed literal checks.
// Expectations follow REGFILE_BYPASS_EN when the macro is defined for the build.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;

    int checks = 0;
    int passes = 0;
    bit checking = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [31:0] model_regs [32];

    regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .re2    (re2),
        .raddr2 (raddr2),
        .rdata2 (rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] expectedRead(input logic en, input logic [4:0] ra);
        if (!rst || !en || ra == 5'd0) return 32'h0;
        if (BYPASS && we && waddr == ra) return wdata;
        return model_regs[ra];
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        end else if (we && waddr != 5'd0) begin
            model_regs[waddr] = wdata;
        end
    end

    // Every cycle after the first edge, both ports must agree with the model.
    always @(negedge clk) begin
        if (checking) begin
            logic [31:0] e1;
            logic [31:0] e2;
            e1 = expectedRead(re1, raddr1);
            e2 = expectedRead(re2, raddr2);
            checks++;
            if (rdata1 === e1) passes++;
            else $display("[TB] FAIL model_port1 t=%0t: got %h expected %h", $time, rdata1, e1);
            checks++;
            if (rdata2 === e2) passes++;
            else $display("[TB] FAIL model_port2 t=%0t: got %h expected %h", $time, rdata2, e2);
        end
    end

    task automatic applyStimulus(input logic r, input logic w, input logic [4:0] wa,
                                 input logic [31:0] wd, input logic e1, input logic [4:0] a1,
                                 input logic e2, input logic [4:0] a2);
        @(posedge clk);
        #1;
        rst = r; we = w; waddr = wa; wdata = wd;
        re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
        checking = 1'b1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] exp1, input logic [31:0] exp2);
        #2;
        checks++;
        if (rdata1 === exp1) passes++;
        else $display("[TB] FAIL %s port1: got %h expected %h", name, rdata1, exp1);
        checks++;
        if (rdata2 === exp2) passes++;
        else $display("[TB] FAIL %s port2: got %h expected %h", name, rdata2, exp2);
    endtask

    initial begin
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;

        applyStimulus(0, 1, 5'd5, 32'hDEADBEEF, 1, 5'd5, 1, 5'd5);
        checkOutput("reset_hold1", 32'h0, 32'h0);
        applyStimulus(0, 1, 5'd5, 32'hDEADBEEF, 1, 5'd5, 1, 5'd5);
        checkOutput("reset_hold2", 32'h0, 32'h0);
        applyStimulus(1, 0, 5'd0, 32'h0, 1, 5'd5, 1, 5'd5);
        checkOutput("post_reset_r5", 32'h0, 32'h0);

        applyStimulus(1, 1, 5'd3, 32'h0000_1234, 0, 5'd3, 0, 5'd3);
        checkOutput("write_r3_no_read", 32'h0, 32'h0);
        applyStimulus(1, 0, 5'd0, 32'h0, 1, 5'd3, 1, 5'd3);
        checkOutput("read_r3", 32'h0000_1234, 32'h0000_1234);

        applyStimulus(1, 1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 1, 5'd0);
        checkOutput("r0_same_cycle", 32'h0, 32'h0);
        applyStimulus(1, 0, 5'd0, 32'h0, 1, 5'd0, 1, 5'd0);
        checkOutput("r0_read", 32'h0, 32'h0);

        applyStimulus(1, 1, 5'd7, 32'hA5A5_A5A5, 0, 5'd0, 0, 5'd0);
        applyStimulus(1, 0, 5'd0, 32'h0, 0, 5'd7, 1, 5'd7);
        checkOutput("re_gating", 32'h0, 32'hA5A5_A5A5);

        applyStimulus(1, 1, 5'd9, 32'h1, 0, 5'd0, 0, 5'd0);
        applyStimulus(1, 1, 5'd9, 32'h2, 1, 5'd9, 0, 5'd9);
        checkOutput("hazard_same_cycle", BYPASS ? 32'h2 : 32'h1, 32'h0);
        applyStimulus(1, 0, 5'd0, 32'h0, 1, 5'd9, 1, 5'd9);
        checkOutput("hazard_next_cycle", 32'h2, 32'h2);

        applyStimulus(1, 1, 5'd10, 32'h11, 0, 5'd0, 0, 5'd0);
        applyStimulus(1, 1, 5'd10, 32'h22, 0, 5'd0, 1, 5'd10);
        checkOutput("b2b_same_cycle", 32'h0, BYPASS ? 32'h22 : 32'h11);
        applyStimulus(1, 0, 5'd0, 32'h0, 1, 5'd10, 0, 5'd0);
        checkOutput("b2b_last_wins", 32'h22, 32'h0);

        for (int i = 1; i < 32; i++) begin
            applyStimulus(1, 1, 5'(i), 32'(i) * 32'h0101_0101, 0, 5'd0, 0, 5'd0);
        end
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1, 0, 5'd0, 32'h0, 1, 5'(i), 1, 5'((32 - i) % 32));
            exp_a = 32'(i) * 32'h0101_0101;
            exp_b = 32'((32 - i) % 32) * 32'h0101_0101;
            checkOutput($sformatf("sweep_%0d", i), exp_a, exp_b);
        end

        applyStimulus(0, 0, 5'd0, 32'h0, 1, 5'd3, 1, 5'd31);
        checkOutput("midstream_reset", 32'h0, 32'h0);
        applyStimulus(1, 1, 5'd4, 32'h55, 1, 5'd3, 1, 5'd31);
        checkOutput("after_reset_cleared", 32'h0, 32'h0);
        applyStimulus(1, 0, 5'd0, 32'h0, 1, 5'd4, 1, 5'd4);
        checkOutput("after_reset_write", 32'h55, 32'h55);

        applyStimulus(1, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0);
        @(posedge clk);
        #1;
        checking = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
